// File: rtl/risc8_sequencer_pkg.sv
// Shared RISC-8 sequencing definitions: instruction class codes, sequencer
// state encoding and the per-step strobe bundle.
package risc8_sequencer_pkg;

  localparam int NCLASS = 26;

  // Codes at or above NCLASS are reserved and execute as a 1-cycle NOP.
  typedef enum logic [4:0] {
    IS_ALU   = 5'd0,  IS_INC  = 5'd1,  IS_DEC   = 5'd2,  IS_COM   = 5'd3,
    IS_MOVW  = 5'd4,  IS_CLX  = 5'd5,  IS_IN    = 5'd6,  IS_OUT   = 5'd7,
    IS_ADIW  = 5'd8,  IS_MULU = 5'd9,  IS_LDS   = 5'd10, IS_LDXYZ = 5'd11,
    IS_LDYZQ = 5'd12, IS_PUSH = 5'd13, IS_POP   = 5'd14, IS_SBIS  = 5'd15,
    IS_LPM   = 5'd16, IS_RJMP = 5'd17, IS_IJMP  = 5'd18, IS_JMP   = 5'd19,
    IS_RCALL = 5'd20, IS_CALL = 5'd21, IS_RET   = 5'd22, IS_BRBC  = 5'd23,
    IS_CPSE  = 5'd24, IS_SBRC = 5'd25
  } instr_class_e;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_EXEC = 2'd1,
    S_SKIP = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_load;
    logic k_load;
    logic mem_req;
  } strobe_t;

endpackage

// File: rtl/risc8_cycle_table.sv
// Combinational schedule: per instruction class and step, the datapath
// strobes, the final-step index and whether a skip sequence is requested.
module risc8_cycle_table
  import risc8_sequencer_pkg::*;
(
  input  logic [4:0] instr,
  input  logic [1:0] step,
  input  logic       skip_cond,
  output strobe_t    strobe,
  output logic [1:0] last,
  output logic       skip_req
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    strobe   = '0;
    last     = 2'd0;
    skip_req = 1'b0;
    case (instr)
      IS_ADIW, IS_MULU: last = 2'd1;
      IS_LDS: begin
        last = 2'd1;
        strobe.k_load  = (step == 2'd0);
        strobe.pc_inc  = (step == 2'd0);
        strobe.mem_req = (step == 2'd1);
      end
      IS_LDXYZ, IS_LDYZQ, IS_PUSH, IS_POP, IS_SBIS: begin
        last = 2'd1;
        strobe.mem_req = (step == 2'd1);
      end
      IS_LPM: begin
        last = 2'd2;
        strobe.mem_req = (step == 2'd1);
      end
      IS_RJMP, IS_IJMP: begin
        last = 2'd1;
        strobe.pc_load = (step == 2'd0);
      end
      IS_JMP: begin
        last = 2'd2;
        strobe.k_load  = (step == 2'd0);
        strobe.pc_inc  = (step == 2'd0);
        strobe.pc_load = (step == 2'd1);
      end
      IS_RCALL: begin
        last = 2'd2;
        strobe.mem_req = (step == 2'd0) || (step == 2'd1);
        strobe.pc_load = (step == 2'd1);
      end
      IS_CALL: begin
        last = 2'd3;
        strobe.k_load  = (step == 2'd0);
        strobe.pc_inc  = (step == 2'd0);
        strobe.mem_req = (step == 2'd1) || (step == 2'd2);
        strobe.pc_load = (step == 2'd2);
      end
      IS_RET: begin
        last = 2'd3;
        strobe.mem_req = (step == 2'd0) || (step == 2'd1);
        strobe.pc_load = (step == 2'd2);
      end
      IS_BRBC: begin
        // A taken branch loads the target in c0 and refills in c1.
        last = (step == 2'd0 && !skip_cond) ? 2'd0 : 2'd1;
        strobe.pc_load = (step == 2'd0) && skip_cond;
      end
      IS_CPSE, IS_SBRC: skip_req = (step == 2'd0) && skip_cond;
      default: ;
    endcase
  end

endmodule

// File: rtl/risc8_sequencer.sv
// RISC-8 multi-cycle sequencer: step counter, skip FSM and memory-wait
// gating wrapped around the per-class cycle table.
module risc8_sequencer
  import risc8_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] instr,
  input  logic       skip_cond,
  input  logic       next_two_word,
  input  logic       mem_ready,
  output logic [1:0] cycle,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       k_load,
  output logic       mem_req,
  output logic       squash,
  output logic       busy
);

  state_e     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       extra, extra_nx;

  strobe_t    stb;
  logic [1:0] last;
  logic       skip_req;
  logic       stall, fin, last_skip;

  risc8_cycle_table u_table (
    .instr     (instr),
    .step      (cnt),
    .skip_cond (skip_cond),
    .strobe    (stb),
    .last      (last),
    .skip_req  (skip_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_BOOT;
      cnt   <= 2'd0;
      extra <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the
      // pre-edge values, independent of statement order.
      state <= state_nx;
      cnt   <= cnt_nx;
      extra <= extra_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    extra_nx  = extra;
    cycle     = 2'd0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    k_load    = 1'b0;
    mem_req   = 1'b0;
    squash    = 1'b0;
    busy      = 1'b0;
    stall     = stb.mem_req & ~mem_ready;
    // ">=" rather than "==" so a code change mid-instruction still terminates.
    fin       = (cnt >= last) & ~skip_req;
    last_skip = extra | ~next_two_word;

    case (state)
      S_BOOT: begin
        ir_load  = 1'b1;
        pc_inc   = 1'b1;
        state_nx = S_EXEC;
        cnt_nx   = 2'd0;
      end
      S_EXEC: begin
        cycle   = cnt;
        mem_req = stb.mem_req;
        pc_inc  = (stb.pc_inc | fin) & ~stall;
        pc_load = stb.pc_load & ~stall;
        k_load  = stb.k_load & ~stall;
        ir_load = fin & ~stall;
        busy    = ~fin;
        if (!stall) begin
          if (skip_req) begin
            state_nx = S_SKIP;
            cnt_nx   = 2'd1;
            extra_nx = 1'b0;
          end else if (fin) begin
            cnt_nx = 2'd0;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
      end
      S_SKIP: begin
        // The extra flag marks the second word of a skipped 2-word opcode.
        cycle   = cnt;
        pc_inc  = 1'b1;
        squash  = 1'b1;
        ir_load = last_skip;
        busy    = ~last_skip;
        if (last_skip) begin
          state_nx = S_EXEC;
          cnt_nx   = 2'd0;
          extra_nx = 1'b0;
        end else begin
          cnt_nx   = cnt + 2'd1;
          extra_nx = 1'b1;
        end
      end
      default: begin
        state_nx = S_BOOT;
        cnt_nx   = 2'd0;
        extra_nx = 1'b0;
      end
    endcase

    if (!reset_n) begin
      cycle   = 2'd0;
      ir_load = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      k_load  = 1'b0;
      mem_req = 1'b0;
      squash  = 1'b0;
      busy    = 1'b0;
    end
  end

endmodule
